act_buffer_reader: RTL

ACT_BUFFER_READER -- requirements
Module: act_buffer_reader

---
 rtl/act_buffer_reader_pkg.sv | 20 ++
 rtl/act_skid_fifo.sv | 61 ++++++
 rtl/act_buffer_reader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/act_buffer_reader_pkg.sv
// Shared definitions for the activation buffer reader: bank index, read FSM states
// and the default depth of the output skid FIFO.
package act_buffer_reader_pkg;

  typedef logic bank_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RELEASE
  } rd_state_t;

  localparam int DEFAULT_FIFO_DEPTH = 4;

  function automatic bank_idx_t other_bank(input bank_idx_t b);
    return ~b;
  endfunction

endpackage

// File: rtl/act_skid_fifo.sv
// Small single-clock valid/ready FIFO used as the output skid buffer.
// Accepts a push while full when the head is popped in the same cycle.
module act_skid_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = (AW)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             pop;
  logic             push_ok;

  assign out_valid = (count_reg != '0);
  assign pop       = out_valid && out_ready;
  assign push_ok   = push && ((count_reg != FULL_COUNT) || pop);
  assign out_data  = mem[rd_ptr_reg];
  assign count     = count_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/act_buffer_reader.sv
// Ping-pong activation buffer reader: replays each filled bank cfg_reps times into
// the systolic array stream, tracking the 2-cycle buffer read latency with tags.
module act_buffer_reader
  import act_buffer_reader_pkg::*;
#(
  parameter int TM         = 128,
  parameter int ADDR_WIDTH = 7,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fill_done,
  input  logic                  fill_sel,
  input  logic [ADDR_WIDTH:0]   fill_k_len,
  input  logic [7:0]            cfg_reps,
  output logic [1:0]            bank_free,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] k_idx,
  output logic                  bank_sel_rd,
  input  logic [TM*8-1:0]       a_vec,
  output logic [TM*8-1:0]       out_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_k_last,
  output logic                  out_last,
  output logic                  err
);

  localparam int DW = TM * 8;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH:0] MAX_KLEN = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] KLEN_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [CW:0]         DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

  rd_state_t             state_reg, state_next;
  bank_idx_t             ptr_reg, ptr_next;
  logic [1:0]            full_reg;
  logic [ADDR_WIDTH:0]   klen_reg [2];
  logic [ADDR_WIDTH-1:0] k_idx_reg, k_idx_next;
  logic [7:0]            reps_reg, reps_next;
  logic [7:0]            rep_cnt_reg, rep_cnt_next;
  logic                  err_reg;
  logic                  s1_valid_reg, s1_k_last_reg, s1_last_reg;
  logic                  s2_valid_reg, s2_k_last_reg, s2_last_reg;

  logic                  issue;
  logic                  release_bank;
  logic                  k_last_hit;
  logic                  rep_last_hit;
  logic                  credit;
  logic                  len_ok;
  logic                  fill_accept;
  logic [1:0]            set_full;
  logic [1:0]            clr_full;
  logic [ADDR_WIDTH:0]   klen_cur;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           outstanding;
  logic [DW+1:0]         fifo_head;
  logic                  fifo_valid;

  // A fill is taken only for a free bank with a sane length; a full bank (including
  // one being read or released this cycle) rejects it.
  assign len_ok      = (fill_k_len != '0) && (fill_k_len <= MAX_KLEN);
  assign fill_accept = fill_done && len_ok && !full_reg[fill_sel];

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign set_full[gi] = fill_accept && (fill_sel == bank_idx_t'(gi));
    assign clr_full[gi] = release_bank && (ptr_reg == bank_idx_t'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg    <= '0;
      klen_reg[0] <= '0;
      klen_reg[1] <= '0;
      err_reg     <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (clr_full[i]) begin
          full_reg[i] <= 1'b0;
        end else if (set_full[i]) begin
          full_reg[i] <= 1'b1;
          klen_reg[i] <= fill_k_len;
        end
      end
      err_reg <= fill_done && !fill_accept;
    end
  end

  assign klen_cur     = klen_reg[ptr_reg];
  assign k_last_hit   = ({1'b0, k_idx_reg} == (klen_cur - KLEN_ONE));
  assign rep_last_hit = (rep_cnt_reg == (reps_reg - 8'd1));

  // Reads already in the tag pipeline will land in the FIFO, so they count as occupied.
  assign outstanding = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid_reg}
                     + {{CW{1'b0}}, s2_valid_reg};
  assign credit      = (outstanding < DEPTH_LIM);

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    k_idx_next   = k_idx_reg;
    reps_next    = reps_reg;
    rep_cnt_next = rep_cnt_reg;
    issue        = 1'b0;
    release_bank = 1'b0;
    case (state_reg)
      IDLE: begin
        if (full_reg[ptr_reg]) begin
          state_next   = ISSUE;
          reps_next    = (cfg_reps == 8'd0) ? 8'd1 : cfg_reps;
          k_idx_next   = '0;
          rep_cnt_next = '0;
        end
      end
      ISSUE: begin
        if (credit) begin
          issue = 1'b1;
          if (k_last_hit) begin
            k_idx_next   = '0;
            rep_cnt_next = rep_cnt_reg + 8'd1;
            if (rep_last_hit) begin
              state_next = DRAIN;
            end
          end else begin
            k_idx_next = k_idx_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!s1_valid_reg && !s2_valid_reg) begin
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        release_bank = 1'b1;
        ptr_next     = other_bank(ptr_reg);
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= 1'b0;
      k_idx_reg     <= '0;
      reps_reg      <= 8'd1;
      rep_cnt_reg   <= '0;
      s1_valid_reg  <= 1'b0;
      s1_k_last_reg <= 1'b0;
      s1_last_reg   <= 1'b0;
      s2_valid_reg  <= 1'b0;
      s2_k_last_reg <= 1'b0;
      s2_last_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      k_idx_reg     <= k_idx_next;
      reps_reg      <= reps_next;
      rep_cnt_reg   <= rep_cnt_next;
      s1_valid_reg  <= issue;
      s1_k_last_reg <= issue && k_last_hit;
      s1_last_reg   <= issue && k_last_hit && rep_last_hit;
      s2_valid_reg  <= s1_valid_reg;
      s2_k_last_reg <= s1_k_last_reg;
      s2_last_reg   <= s1_last_reg;
    end
  end

  act_skid_fifo #(
    .WIDTH (DW + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s2_valid_reg),
    .push_data ({s2_k_last_reg, s2_last_reg, a_vec}),
    .out_data  (fifo_head),
    .out_valid (fifo_valid),
    .out_ready (out_ready),
    .count     (fifo_count)
  );

  assign bank_free   = ~full_reg;
  assign rd_en       = issue;
  assign k_idx       = k_idx_reg;
  assign bank_sel_rd = ptr_reg;
  assign err         = err_reg;
  assign out_valid   = fifo_valid;
  assign out_vec     = fifo_valid ? fifo_head[DW-1:0] : '0;
  assign out_k_last  = fifo_valid && fifo_head[DW+1];
  assign out_last    = fifo_valid && fifo_head[DW];

endmodule
